// File: rtl/hilo_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_unit_pkg
// Description : Shared encodings for the HI/LO multiply/divide unit: the
//               operation codes seen on the op port and the control FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIN  = 2'b11
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_unit_divu_core.sv
`default_nettype none
// ============================================================================
// Module      : divu_core
// Description : Iterative restoring unsigned divider, one quotient bit per
//               cycle. The first iteration is done on the loading edge from
//               the dividend/divisor inputs, so WIDTH iterations complete
//               WIDTH-1 edges after start; busy drops once results are final.
//               Requires WIDTH >= 2.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start               - load operands (ignored while busy)
//               dividend, divisor   - operands, sampled only on start
//               busy                - iterations still outstanding
//               quotient, remainder - result registers
// Revision    : 1.0 - initial release
// ============================================================================
module divu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load;
  logic [WIDTH-1:0] rem_src, quot_src, div_src;
  logic [WIDTH:0]   shifted, trial;
  logic             borrow;

  assign busy      = (cnt_q != '0);
  assign load      = start && !busy;
  assign quotient  = quot_q;
  assign remainder = rem_q;

  always_comb begin
    // On load the step runs straight from the inputs with a zero remainder.
    rem_src  = load ? '0       : rem_q;
    quot_src = load ? dividend : quot_q;
    div_src  = load ? divisor  : div_q;

    // The shifted remainder can reach 2*divisor-1, so the trial subtract is
    // one bit wider than the operands; its MSB is then a true borrow.
    shifted = {rem_src, quot_src[WIDTH-1]};
    trial   = shifted - {1'b0, div_src};
    borrow  = trial[WIDTH];

    rem_d  = rem_q;
    quot_d = quot_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (load || busy) begin
      rem_d  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quot_d = {quot_src[WIDTH-2:0], ~borrow};
    end
    if (load) begin
      div_d = divisor;
      cnt_d = CNT_W'(WIDTH - 1);
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mulu.sv
`default_nettype none
// ============================================================================
// Module      : mulu
// Description : Combinational unsigned multiplier, full 2*WIDTH-bit product.
// Ports       : a, b    - WIDTH-bit unsigned operands
//               product - 2*WIDTH-bit unsigned product
// Revision    : 1.0 - initial release
// ============================================================================
module mulu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  // Zero-extend before multiplying so the full product width is kept.
  assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_unit
// Description : HI/LO register pair with MULTU, DIVU, MTHI and MTLO.
//               MULTU takes 2 cycles, DIVU (b!=0) WIDTH+1 cycles, DIVU by
//               zero 1 cycle; moves complete on the accepting edge.
// Ports       : clk, rst_n - clock, async active-low reset
//               start, op  - request strobe and operation code
//               a, b       - operands
//               busy       - MUL/DIV/FIN in progress
//               done       - one-cycle pulse, result visible on hi/lo
//               dz         - sticky divide-by-zero flag of last DIVU
//               hi, lo     - HI and LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic               accept;
  logic               div_start;
  logic               div_busy;
  logic [WIDTH-1:0]   div_quot, div_rem;
  logic [2*WIDTH-1:0] product;

  // busy_q is high in every non-IDLE state, so this also implies IDLE.
  assign accept    = start && !busy_q;
  assign div_start = accept && (op_e'(op) == OP_DIVU) && (b != '0);

  mulu #(.WIDTH(WIDTH)) u_mulu (
    .a       (a_q),
    .b       (b_q),
    .product (product)
  );

  divu_core #(.WIDTH(WIDTH)) u_divu_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d = a;
          b_d = b;
          case (op_e'(op))
            OP_MULTU: state_d = S_MUL;
            OP_DIVU: begin
              if (b == '0) begin
                // Divide by zero resolves immediately; FIN shows the result.
                state_d = S_FIN;
                hi_d    = a;
                lo_d    = '1;
                dz_d    = 1'b1;
              end else begin
                state_d = S_DIV;
                dz_d    = 1'b0;
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        hi_d    = product[2*WIDTH-1:WIDTH];
        lo_d    = product[WIDTH-1:0];
        state_d = S_FIN;
      end
      S_DIV: begin
        if (!div_busy) begin
          hi_d    = div_rem;
          lo_d    = div_quot;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_unit
// Description : Self-checking bench for hilo_unit at WIDTH=32: a table of
//               directed operations plus hand-written sequences for moves on
//               consecutive cycles, start while busy, back-to-back requests
//               and reset during a divide.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, dz;
  logic [WIDTH-1:0] hi, lo;

  int ntests = 0;
  int nfail  = 0;

  hilo_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;   // cycle (after accept) in which done is seen; 0 = move
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int  k;
    bit  seen;
    bit  busy_gap;
    seen     = 0;
    busy_gap = 0;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clk);
    #1;
    // Scramble inputs so the running operation must use latched copies.
    start = 1'b0; a = $urandom; b = $urandom;
    if (v.lat == 0) begin
      chk({v.name, ".hi"}, hi, v.hi);
      chk({v.name, ".lo"}, lo, v.lo);
      chk({v.name, ".busy"}, busy, 0);
      chk({v.name, ".done"}, done, 0);
      chk({v.name, ".dz"}, dz, v.dz);
      @(negedge clk);
      chk({v.name, ".done_after"}, done, 0);
    end else begin
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        if (!busy) busy_gap = 1;
        if (done) begin
          k    = i;
          seen = 1;
          break;
        end
      end
      if (!seen) begin
        chk({v.name, ".timeout"}, 0, 1);
      end else begin
        chk({v.name, ".lat"}, k, v.lat);
        chk({v.name, ".busy_held"}, busy_gap, 0);
        chk({v.name, ".hi"}, hi, v.hi);
        chk({v.name, ".lo"}, lo, v.lo);
        chk({v.name, ".dz"}, dz, v.dz);
        @(negedge clk);
        chk({v.name, ".idle_busy"}, busy, 0);
        chk({v.name, ".idle_done"}, done, 0);
      end
    end
  endtask

  initial begin
    int  k;
    bit  seen;
    logic [3:0] bpat, dpat;

    vecs[0]  = '{"mul_max",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2};
    vecs[1]  = '{"div_100_7",  2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[2]  = '{"div_by0",    2'b01, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    vecs[3]  = '{"mul_keepdz", 2'b00, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 1'b1, 2};
    vecs[4]  = '{"div_9_3",    2'b01, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0, 33};
    vecs[5]  = '{"mthi",       2'b10, 32'hA5A5A5A5, 32'd0,        32'hA5A5A5A5, 32'd3,        1'b0, 0};
    vecs[6]  = '{"mtlo",       2'b11, 32'h5A5A5A5A, 32'd0,        32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 0};
    vecs[7]  = '{"mul_2p16sq", 2'b00, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0, 2};
    vecs[8]  = '{"div_by1",    2'b01, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33};
    vecs[9]  = '{"div_small",  2'b01, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0, 33};
    vecs[10] = '{"div_msb_3",  2'b01, 32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 1'b0, 33};
    vecs[11] = '{"div_wide",   2'b01, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 33};
    vecs[12] = '{"div_self",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33};
    vecs[13] = '{"mul_zero",   2'b00, 32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0, 2};

    // Reset state
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.dz",   dz,   0);
    chk("rst.hi",   hi,   0);
    chk("rst.lo",   lo,   0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hA5A5A5A5;
    @(negedge clk);
    chk("mtseq.busy1", busy, 0);
    chk("mtseq.done1", done, 0);
    op = 2'b11; a = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0;
    chk("mtseq.busy2", busy, 0);
    chk("mtseq.done2", done, 0);
    chk("mtseq.hi", hi, 32'hA5A5A5A5);
    chk("mtseq.lo", lo, 32'h5A5A5A5A);

    // Start while busy is ignored, not queued; inputs changed mid-divide
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd10;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'd0; b = 32'd0;
    seen = 0; k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 5) begin start = 1'b1; op = 2'b11; a = 32'hDEADBEEF; end
      if (i == 8) start = 1'b0;
      if (done) begin k = i; seen = 1; break; end
    end
    chk("ign.seen", seen, 1);
    chk("ign.lat", k, 33);
    chk("ign.lo", lo, 32'd100);
    chk("ign.hi", hi, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("ign.lo_after", lo, 32'd100);
    chk("ign.busy_after", busy, 0);

    // start held high: next acceptance is the cycle after FIN
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    bpat = '0; dpat = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bpat[i] = busy;
      dpat[i] = done;
    end
    start = 1'b0;
    chk("b2b.busy_pat", bpat, 4'b1011);
    chk("b2b.done_pat", dpat, 4'b0010);
    @(negedge clk);
    chk("b2b.done2", done, 1);
    chk("b2b.lo", lo, 32'd42);
    @(negedge clk);

    // Reset in the middle of a divide
    run_op('{"mul_pre", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2});
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.hi", hi, 0);
    chk("arst.lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op('{"mul_3x5", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 2});
    for (int i = 0; i < 40; i++) @(negedge clk);
    chk("arst.hold_lo", lo, 32'd15);
    chk("arst.hold_hi", hi, 32'd0);
    chk("arst.hold_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width; HI and LO are each WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request strobe, sampled on each rising edge.
REQ-005 op  input  2  operation: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 a  input  WIDTH  multiplicand, dividend, or move source.
REQ-007 b  input  WIDTH  multiplier or divisor.
REQ-008 busy  output  1  high while a MULTU or DIVU is in flight.
REQ-009 done  output  1  one-cycle pulse when a MULTU or DIVU result is written.
REQ-010 dz  output  1  sticky divide-by-zero flag for the last DIVU.
REQ-011 hi  output  WIDTH  HI register, driven directly from the register.
REQ-012 lo  output  WIDTH  LO register, driven directly from the register.

Function
REQ-013 A request shall be accepted on a rising edge where start=1 and busy=0.
REQ-014 Whenever busy=1, start shall be ignored and never queued.
REQ-015 FSM states shall be IDLE, MUL, DIV and FIN.
REQ-016 Transitions:
- IDLE->MUL on an accepted MULTU.
- IDLE->DIV on an accepted DIVU with b!=0.
- IDLE->FIN on an accepted DIVU with b==0.
- MUL->FIN after 1 cycle.
- DIV->FIN after WIDTH iterations.
- FIN->IDLE unconditionally.
REQ-017 On acceptance, a and b shall be latched into internal operand registers; later input changes shall have no effect on the running operation.
REQ-018 MULTU: {hi,lo} shall equal the full 2*WIDTH-bit unsigned product of the latched operands.
REQ-019 MULTU shall be written on the edge that leaves MUL, i.e. the second edge after acceptance.
REQ-020 DIVU shall use restoring division at one quotient bit per cycle: shift {rem,quot} left, trial-subtract the divisor, and keep the result if it does not borrow.
REQ-021 DIVU result: lo=quotient and hi=remainder, written on the edge that leaves DIV, i.e. edge WIDTH+1 after acceptance.
REQ-022 The divisor trial subtraction shall be WIDTH+1 bits wide so the borrow is never lost.
REQ-023 DIVU with b==0 shall write lo=all ones and hi=a on the edge after acceptance and set dz=1.
REQ-024 Any DIVU with b!=0 shall clear dz on acceptance.
REQ-025 MTHI shall write hi=a, and MTLO shall write lo=a, on the accepting edge; busy shall stay 0 and done shall not pulse.
REQ-026 busy shall be 1 exactly while the state is MUL, DIV or FIN.
REQ-027 done shall be 1 exactly while the state is FIN (one cycle); hi and lo shall already hold the result in that cycle.
REQ-028 A new request shall be accepted on the edge that leaves FIN only if busy has deasserted, so the earliest back-to-back acceptance is the cycle after FIN.
REQ-029 hi and lo shall otherwise hold their value indefinitely.
REQ-030 Arithmetic shall be unsigned only; no overflow or exception is possible except dz.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0, and operand/iteration registers=0.
REQ-032 Reset asserted mid-MULTU or mid-DIVU shall abort the operation with no partial write surviving.
REQ-033 After rst_n rises, the first start shall be accepted normally.

Structure
REQ-034 The op encodings and FSM state encodings shall live in a shared package/header used by the datapath and the decoder.
REQ-035 The iterative divider shall be one sub-module, divu_core, with ports start, busy, quotient and remainder.
REQ-036 The product shall come from the team's combinational mulu block instantiated at WIDTH, fed from the latched operands.
REQ-037 The iteration counter shall be clog2(WIDTH)+1 bits.

Verification (WIDTH=32)
REQ-038 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done on cycle 2 after acceptance; hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 DIVU a=100, b=7 -> busy for 33 cycles; done in the 33rd; lo=14, hi=2, dz=0.
REQ-040 DIVU a=0x1234, b=0 -> done the cycle after acceptance; lo=0xFFFFFFFF, hi=0x1234, dz=1; a following DIVU 9/3 -> dz=0, lo=3, hi=0.
REQ-041 MTHI a=0xA5A5A5A5, then MTLO a=0x5A5A5A5A on consecutive cycles -> hi=0xA5A5A5A5, lo=0x5A5A5A5A; busy and done stay 0.
REQ-042 DIVU 1000/10, then start=1 with op=MTLO at cycle 5 -> the MTLO is ignored; final lo=100, hi=0.
REQ-043 Start DIVU 1000/10, assert rst_n=0 at cycle 10 -> immediately busy=0, hi=lo=0; after release, MULTU 3*5 -> lo=15, hi=0.
